parking_gate_ctrl: RTL

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_pkg.sv | 20 ++
 rtl/parking_gate_ctrl_if.sv | 36 +++
 rtl/parking_counter.sv | 81 ++++++++
 rtl/parking_gate_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate controller.
//   - gate FSM state encoding (2 bits: IDLE=0, OPEN=1, DRAIN=2)
//   - default CAPACITY, CNT_W and GATE_TICKS values used by the modules
package parking_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OPEN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    GATE_IDLE  = ST_IDLE,
    GATE_OPEN  = ST_OPEN,
    GATE_DRAIN = ST_DRAIN
  } gate_state_e;

  localparam int DEF_CAPACITY   = 15;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_GATE_TICKS = 100;

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Signal bundle between the parking gate controller and its environment.
//   master : drives entry_req, enter, exit, clear; observes status
//   slave  : the controller; observes requests, drives gate_open, timeout,
//            count, full, empty, overflow_err, underflow_err, gate_state
// Handshake: there is no valid/ready pair here. entry_req is a level that
// stays high while a car waits; enter/exit are sampled every cycle and only
// their rising edges matter; clear is a one-cycle-or-longer synchronous
// command. gate_state is a debug view of the gate FSM.
interface parking_gate_ctrl_if #(
  parameter int CNT_W = parking_pkg::DEF_CNT_W
);
  logic             entry_req;
  logic             enter;
  logic             exit;
  logic             clear;
  logic             gate_open;
  logic             timeout;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow_err;
  logic             underflow_err;
  logic [1:0]       gate_state;

  modport master (
    output entry_req, enter, exit, clear,
    input  gate_open, timeout, count, full, empty,
           overflow_err, underflow_err, gate_state
  );

  modport slave (
    input  entry_req, enter, exit, clear,
    output gate_open, timeout, count, full, empty,
           overflow_err, underflow_err, gate_state
  );
endinterface

// File: rtl/parking_counter.sv
// Occupancy counter: rising-edge detection on enter/exit, saturating count,
// full/empty decode, sticky overflow/underflow flags and synchronous clear.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   enter, exit         car-passed indications (pulse or level)
//   clear               synchronous clear of count and error flags
//   enter_ev            registered-once entry event (used by the gate FSM)
//   count, full, empty  occupancy and its decodes
//   overflow_err, underflow_err  sticky error flags
module parking_counter #(
  parameter int CAPACITY = parking_pkg::DEF_CAPACITY,
  parameter int CNT_W    = parking_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enter,
  input  logic             exit,
  input  logic             clear,
  output logic             enter_ev,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic             enter_q, exit_q;
  // Arm bits stay low after reset until the input has been seen low, so a
  // level that was already high across reset release is not taken as an edge.
  logic             enter_arm_q, exit_arm_q;
  logic             exit_ev;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q, unf_q;

  assign enter_ev = enter & ~enter_q & enter_arm_q;
  assign exit_ev  = exit  & ~exit_q  & exit_arm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enter_q     <= 1'b0;
      exit_q      <= 1'b0;
      enter_arm_q <= 1'b0;
      exit_arm_q  <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      enter_q     <= enter;
      exit_q      <= exit;
      enter_arm_q <= enter_arm_q | ~enter;
      exit_arm_q  <= exit_arm_q  | ~exit;
      if (clear) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
      end else begin
        // Simultaneous entry and exit cancel: no change, no flag.
        case ({enter_ev, exit_ev})
          2'b10: begin
            if (count_q == CAP) ovf_q <= 1'b1;
            else                count_q <= count_q + CNT_W'(1);
          end
          2'b01: begin
            if (count_q == '0) unf_q <= 1'b1;
            else               count_q <= count_q - CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign count         = count_q;
  assign full          = (count_q == CAP);
  assign empty         = (count_q == '0);
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking entry gate controller: gate FSM (IDLE/OPEN/DRAIN) with an open
// timer, plus the occupancy counter sub-module.
// Ports:
//   clk      system clock
//   reset_n  async active-low reset
//   bus      parking_gate_ctrl_if.slave (requests in, gate/status out,
//            gate_state debug view of the FSM)
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY   = DEF_CAPACITY,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GATE_TICKS = DEF_GATE_TICKS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  parking_gate_ctrl_if.slave    bus
);

  localparam int TW = (GATE_TICKS > 2) ? $clog2(GATE_TICKS) : 1;
  localparam logic [TW-1:0] TICKS_M1 = TW'(GATE_TICKS - 1);

  gate_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
  logic          enter_ev;
  logic          full;

  parking_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_counter (
    .clk           (clk),
    .reset_n       (reset_n),
    .enter         (bus.enter),
    .exit          (bus.exit),
    .clear         (bus.clear),
    .enter_ev      (enter_ev),
    .count         (bus.count),
    .full          (full),
    .empty         (bus.empty),
    .overflow_err  (bus.overflow_err),
    .underflow_err (bus.underflow_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= GATE_IDLE;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    case (state_q)
      GATE_IDLE: begin
        if (bus.entry_req && !full) begin
          state_d = GATE_OPEN;
          timer_d = TICKS_M1;
        end
      end
      GATE_OPEN: begin
        // A car passing wins over expiry in the same cycle: no timeout.
        if (enter_ev) begin
          state_d = GATE_DRAIN;
        end else if (timer_q == '0) begin
          state_d   = GATE_DRAIN;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      GATE_DRAIN: begin
        // Wait for the request to drop so one waiting car gets one opening.
        if (!bus.entry_req) state_d = GATE_IDLE;
      end
      default: begin
        state_d = GATE_IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign bus.gate_open  = (state_q == GATE_OPEN);
  assign bus.timeout    = timeout_q;
  assign bus.full       = full;
  assign bus.gate_state = state_q;

endmodule
